// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow memory port between the instruction (I) and data (D) L2
//   caches. A winning request is latched onto the mem_* registers, held until
//   mem_ready, and the read line plus a one-cycle ready pulse go back to the
//   winner. The FSM walks IDLE -> BUSY -> DONE -> IDLE.
//
//   Arbitration is round-robin on ties. Defining ARB_D_PRIORITY_EN makes D win
//   ties instead. A starvation guard then hands I every ninth tie.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_read/i_write          I request (level, held until i_ready)
//   i_addr/i_wdata          I line address / write line
//   i_rdata/i_ready         I read line / one-cycle completion pulse
//   d_*                     same set for channel D
//   mem_read/mem_write      memory command (registered)
//   mem_addr/mem_wdata      memory line address / write line (registered)
//   mem_rdata/mem_ready     memory read line / completion pulse
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q;
  logic                owner_q;       // 0 = I, 1 = D
  logic                last_grant_q;  // 0 = I, 1 = D
  logic                mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ready_q, d_ready_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  logic                i_req, d_req, pick_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                mem_read_d, mem_write_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef ARB_D_PRIORITY_EN
  // Consecutive D grants taken while I was waiting; the ninth tie goes to I.
  logic [3:0] d_streak_q;
  assign pick_d = d_req & (~i_req | (d_streak_q != 4'd8));
`else
  // On a tie the channel that did not win last time goes next.
  assign pick_d = d_req & (~i_req | ~last_grant_q);
`endif

  // Command for the winner; a write beats a read on the same channel.
  assign mem_addr_d  = pick_d ? d_addr  : i_addr;
  assign mem_wdata_d = pick_d ? d_wdata : i_wdata;
  assign mem_write_d = pick_d ? d_write : i_write;
  assign mem_read_d  = (pick_d ? d_read : i_read) & ~mem_write_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
`ifdef ARB_D_PRIORITY_EN
      d_streak_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            owner_q      <= pick_d;
            last_grant_q <= pick_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            state_q      <= BUSY;
`ifdef ARB_D_PRIORITY_EN
            if (!pick_d)    d_streak_q <= 4'd0;
            else if (i_req) d_streak_q <= d_streak_q + 4'd1;
`endif
          end
        end
        BUSY: begin
          // Requester lines are ignored here; the latched command stands.
          if (mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q) begin
              d_ready_q <= 1'b1;
              if (!mem_write_q) d_rdata_q <= mem_rdata;
            end else begin
              i_ready_q <= 1'b1;
              if (!mem_write_q) i_rdata_q <= mem_rdata;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // Requests are not sampled here, so the finished one is not re-granted.
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
`ifdef ARB_D_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk_w(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_b(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chk_i(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- input snapshot at the active edge ----------------
  logic          s_rst = 1'b0, s_ir = 1'b0, s_iw = 1'b0, s_dr = 1'b0, s_dw = 1'b0, s_mr = 1'b0;
  logic [AW-1:0] s_ia = '0, s_da = '0;
  logic [DW-1:0] s_iwd = '0, s_dwd = '0, s_mrd = '0;

  initial forever begin
    @(posedge clk);
    s_rst = rst_n; s_ir = i_read; s_iw = i_write; s_dr = d_read; s_dw = d_write;
    s_ia = i_addr; s_da = d_addr; s_iwd = i_wdata; s_dwd = d_wdata;
    s_mr = mem_ready; s_mrd = mem_rdata;
  end

  // ---------------- transaction-level reference model ----------------
  // One command in flight at most; after completion one edge is lost before
  // the arbiter looks at requests again.
  bit            m_act, m_cool, m_owner, m_wr, m_lastg, m_irdy, m_drdy, m_mr, m_mw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ird, m_drd;
  int            m_streak;

  task automatic model_step();
    bit ireq, dreq, win;
    m_irdy = 1'b0;
    m_drdy = 1'b0;
    ireq = s_ir | s_iw;
    dreq = s_dr | s_dw;
    if (m_act) begin
      if (s_mr) begin
        m_act = 1'b0; m_cool = 1'b1; m_mr = 1'b0; m_mw = 1'b0;
        if (m_owner) begin m_drdy = 1'b1; if (!m_wr) m_drd = s_mrd; end
        else         begin m_irdy = 1'b1; if (!m_wr) m_ird = s_mrd; end
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (ireq || dreq) begin
      if (ireq && dreq) win = PRIO ? (m_streak < 8) : !m_lastg;
      else              win = dreq;
      if (!win)      m_streak = 0;
      else if (ireq) m_streak = m_streak + 1;
      m_lastg = win; m_owner = win; m_act = 1'b1;
      m_wr    = win ? s_dw  : s_iw;
      m_addr  = win ? s_da  : s_ia;
      m_wdata = win ? s_dwd : s_iwd;
      m_mr = !m_wr; m_mw = m_wr;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_act = 0; m_cool = 0; m_owner = 0; m_wr = 0; m_lastg = 1; m_irdy = 0; m_drdy = 0;
      m_mr = 0; m_mw = 0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0; m_streak = 0;
    end else if (s_rst) begin
      model_step();
    end
    chk_b("mem_read", mem_read, m_mr);
    chk_b("mem_write", mem_write, m_mw);
    chk_w("mem_addr", DW'(mem_addr), DW'(m_addr));
    chk_w("mem_wdata", mem_wdata, m_wdata);
    chk_b("i_ready", i_ready, m_irdy);
    chk_b("d_ready", d_ready, m_drdy);
    chk_w("i_rdata", i_rdata, m_ird);
    chk_w("d_rdata", d_rdata, m_drd);
  end

  // ---------------- memory responder ----------------
  int            mem_lat = 2;
  bit            mem_rand = 1'b0;
  logic [DW-1:0] mem_fix = '0;
  bit            mr_sent = 1'b0;
  int            mr_cnt = 0;

  initial forever begin
    @(negedge clk); #2;
    mem_ready = 1'b0;
    if (mem_read || mem_write) begin
      if (!mr_sent) begin
        if (mr_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_rand ? rnd_line() : mem_fix;
          mr_sent = 1'b1;
        end else mr_cnt--;
      end
    end else begin
      mr_sent = 1'b0;
      mr_cnt  = mem_rand ? int'($urandom_range(0, 4)) : mem_lat;
      // stray completions while nothing is outstanding must be ignored
      if (mem_rand && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rnd_line();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic clear_req();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic new_req(input bit ch);
    int op;
    op = $urandom_range(0, 2);  // 0 read, 1 write, 2 both
    if (ch) begin
      d_read = (op != 1); d_write = (op != 0); d_addr = AW'($urandom); d_wdata = rnd_line();
    end else begin
      i_read = (op != 1); i_write = (op != 0); i_addr = AW'($urandom); i_wdata = rnd_line();
    end
  endtask

  int ord[18];

  initial begin
    int n, t, k, first, ni, nd, ncmd, gap, ntx;
    bit prev, cmd, seen;

    // reset state
    cyc(); cyc();
    chk_b("reset mem_read", mem_read, 1'b0);
    chk_w("reset mem_addr", DW'(mem_addr), '0);
    chk_b("reset i_ready", i_ready, 1'b0);
    chk_w("reset d_rdata", d_rdata, '0);
    rst_n = 1'b1;

    // single read from I, memory answers five cycles later
    mem_lat = 4; mem_fix = {16{8'hA5}};
    i_read = 1; i_addr = 28'h0000040;
    cyc();
    chk_b("t1 mem_read", mem_read, 1'b1);
    chk_w("t1 mem_addr", DW'(mem_addr), DW'(28'h0000040));
    n = 0;
    while (i_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    chk_i("t1 ready latency", n, 5);
    chk_w("t1 i_rdata", i_rdata, {16{8'hA5}});
    chk_b("t1 d_ready", d_ready, 1'b0);
    i_read = 0;
    cyc();
    chk_b("t1 ready one cycle", i_ready, 1'b0);
    cyc();

    // write wins over read on the same channel; rdata untouched by a write
    mem_lat = 1;
    d_read = 1; d_write = 1; d_addr = 28'h0000100; d_wdata = 128'h1234;
    cyc();
    chk_b("t2 mem_write", mem_write, 1'b1);
    chk_b("t2 mem_read", mem_read, 1'b0);
    chk_w("t2 mem_wdata", mem_wdata, 128'h1234);
    n = 0;
    while (d_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    chk_b("t2 d_ready seen", d_ready, 1'b1);
    chk_w("t2 d_rdata kept", d_rdata, '0);
    clear_req();
    cyc(); cyc();

    // simultaneous requests after reset
    do_reset();
    mem_lat = 2; i_read = 1; d_read = 1; i_addr = 28'h0000200; d_addr = 28'h0000300;
    first = -1; ni = 0; nd = 0; ncmd = 0; prev = 0; t = 0;
    while ((i_read || d_read) && t < 60) begin
      cyc(); t++;
      cmd = mem_read | mem_write;
      if (cmd && !prev) ncmd++;
      prev = cmd;
      if (i_ready) begin ni++; i_read = 0; if (first < 0) first = 0; end
      if (d_ready) begin nd++; d_read = 0; if (first < 0) first = 1; end
    end
    for (int j = 0; j < 5; j++) begin
      cyc();
      cmd = mem_read | mem_write;
      if (cmd && !prev) ncmd++;
      prev = cmd;
      if (i_ready) ni++;
      if (d_ready) nd++;
    end
    chk_i("t3 first winner", first, PRIO ? 1 : 0);
    chk_i("t3 commands", ncmd, 2);
    chk_i("t3 i pulses", ni, 1);
    chk_i("t3 d pulses", nd, 1);

    // continuous contention: grant order and inter-command gap
    do_reset();
    mem_lat = 1; i_read = 1; d_read = 1;
    ntx = PRIO ? 18 : 6;
    k = 0; t = 0; prev = 0; gap = 0; seen = 0;
    while (k < ntx && t < 400) begin
      cyc(); t++;
      cmd = mem_read | mem_write;
      if (cmd && !prev) begin
        if (seen) chk_i("t4 gap", gap, 2);
        seen = 1; gap = 0;
      end
      if (!cmd) gap++;
      prev = cmd;
      if (i_ready)      begin ord[k] = 0; k++; end
      else if (d_ready) begin ord[k] = 1; k++; end
      i_read = !i_ready;  // drop in the ready cycle, request again after
      d_read = !d_ready;
    end
    clear_req();
    chk_i("t4 transactions", k, ntx);
    for (int j = 0; j < ntx; j++)
      chk_i($sformatf("t4 grant[%0d]", j), ord[j], PRIO ? ((j % 9 == 8) ? 0 : 1) : j % 2);
    cyc(); cyc();

    // reset in the middle of a transaction
    mem_lat = 10; i_read = 1; i_addr = 28'h0000abc;
    cyc(); cyc();
    chk_b("t5 busy mem_read", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_b("t5 async mem_read", mem_read, 1'b0);
    chk_w("t5 async mem_addr", DW'(mem_addr), '0);
    chk_b("t5 async i_ready", i_ready, 1'b0);
    cyc();
    clear_req();
    rst_n = 1'b1;
    mem_lat = 0; i_read = 1; d_read = 1;
    first = -1; t = 0;
    while (first < 0 && t < 30) begin
      cyc(); t++;
      if (i_ready) first = 0;
      else if (d_ready) first = 1;
    end
    chk_i("t5 first after reset", first, PRIO ? 1 : 0);
    clear_req();
    cyc(); cyc(); cyc();

    // random traffic with occasional resets
    mem_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (i_ready) begin i_read = 0; i_write = 0; end
      else if (!(i_read || i_write) && $urandom_range(0, 2) == 0) new_req(1'b0);
      if (d_ready) begin d_read = 0; d_write = 0; end
      else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) new_req(1'b1);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        cyc();
        clear_req();
        rst_n = 1'b1;
      end
    end
    clear_req();
    cyc(); cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow-memory port between two L2 cache requesters: channel I (instruction) and channel D (data).
- Sits between the I/D L2 caches and the single off-chip memory interface.
- Latches the winning request, holds it on the memory port until mem_ready, then returns the ready pulse and read data to the winner.
- Round-robin arbitration by default; optional fixed data priority.

Parameters:
- ADDR_W, 28, block address width (byte address bits [31:4]).
- DATA_W, 128, cache line width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  channel I read request, level, held until i_ready.
- i_write  in  1  channel I write request, level, held until i_ready.
- i_addr  in  ADDR_W  channel I line address.
- i_wdata  in  DATA_W  channel I write line.
- i_rdata  out  DATA_W  channel I read line, valid with i_ready.
- i_ready  out  1  channel I completion, one-cycle pulse.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the I ports, for channel D.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  DATA_W  memory write line.
- mem_rdata  in  DATA_W  memory read line.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n; all state registers clear immediately when rst_n falls.
- Reset values:
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - i_ready=0, d_ready=0, i_rdata=0, d_rdata=0.
  - State=IDLE; last_grant=D, so I wins the first tie.
- State IDLE:
  - A channel is requesting when its read OR write is high.
  - Only one channel requesting: grant it.
  - Both requesting: grant the channel that is not last_grant.
  - On grant, at the clock edge: latch addr, wdata and op into the mem_* output registers, set owner and last_grant, go to BUSY.
  - If write and read are both high on the granted channel, write wins; only mem_write asserts.
  - Nothing requesting: stay in IDLE with mem_read=mem_write=0.
- State BUSY:
  - mem_* outputs stay constant; requester inputs are ignored.
  - On mem_ready=1, at the edge: clear mem_read/mem_write, register mem_rdata into the owner's rdata, pulse the owner's ready for exactly one cycle, go to DONE.
  - The non-owner's ready stays 0.
- State DONE:
  - One cycle while the owner's ready is high. The requester drops its request in this cycle.
  - The request lines are not sampled here, so the completed request is never re-granted.
  - Go to IDLE.
- Timing:
  - Request to mem command: 1 cycle.
  - mem_ready to requester ready: 1 cycle.
  - Minimum gap between consecutive memory commands: 2 cycles (DONE, then IDLE arbitration).
- Read data: i_rdata and d_rdata hold their last captured value until the next completion for that channel. Writes do not update rdata.
- Request dropped while BUSY (protocol violation): the transaction still completes and ready still pulses.
- Address and data width: passed through unmodified; no arithmetic.
- mem_ready in IDLE or DONE: ignored.
- Reset mid-transaction: outputs return to reset values immediately, the pending transaction is abandoned, and neither ready pulses.

Optional Feature:
- Macro: ARB_D_PRIORITY_EN.
- Defined:
  - In IDLE, channel D always wins when both channels request.
  - Starvation guard: a 4-bit counter counts consecutive D grants taken while I was requesting.
  - When the count reaches 8, the next tie goes to I and the counter clears.
  - The counter also clears on any I grant and on reset.
- Undefined: pure round-robin as described in Behaviour; the counter is not present.

Test Plan:
- Single read: i_read=1, i_addr=28'h0000040. mem_read=1, mem_addr=28'h0000040 one cycle later. Memory returns mem_rdata=128'hA5..A5 with mem_ready after 5 cycles. Next cycle i_ready=1 for one cycle with i_rdata=128'hA5..A5; d_ready stays 0.
- Write precedence: d_read=1 and d_write=1, d_addr=28'h0000100, d_wdata=128'h1234. Only mem_write=1, with mem_wdata=128'h1234.
- Simultaneous requests after reset: i_read and d_read both high, each held until its own ready. I is granted first, then D. Exactly 2 memory commands; each channel's ready pulses once.
- Back-to-back fairness: both channels request continuously for 6 transactions. Grant order is I,D,I,D,I,D. There is a 2-cycle gap between mem_ready and the next mem_read.
- Reset mid-BUSY: assert rst_n=0 while mem_read=1. mem_read=0 asynchronously, with no clock edge needed. After release: IDLE, and the next tie goes to I.
- ARB_D_PRIORITY_EN defined, both channels requesting continuously: D is granted 8 times, then I once, then the D-first pattern repeats.
